// File: rtl/select_encode_unit_pkg.sv
// select_encode_unit_pkg: IR field positions and sizes shared by the select/encode datapath
package select_encode_unit_pkg;
    localparam int OPC_MSB = 31;
    localparam int RA_MSB  = 26;
    localparam int RB_MSB  = 22;
    localparam int RC_MSB  = 18;
    localparam int FLD_W   = 4;
    localparam int C_W     = 19;
    localparam int NREG    = 16;
    localparam int OPC_W   = OPC_MSB - RA_MSB;

    function automatic logic [FLD_W-1:0] field(input logic [31:0] ir, input int msb);
        return ir[msb -: FLD_W];
    endfunction
endpackage

// File: rtl/select_encode_unit_decoder_4to16.sv
// decoder_4to16: enable-gated one-hot decoder
//   en_i  : enable, output is all-zero when low
//   sel_i : register index
//   y_o   : one-hot of sel_i
module decoder_4to16
    import select_encode_unit_pkg::*;
(
    input  logic             en_i,
    input  logic [FLD_W-1:0] sel_i,
    output logic [NREG-1:0]  y_o
);
    assign y_o = en_i ? NREG'(1) << sel_i : '0;
endmodule

// File: rtl/select_encode_unit.sv
// select_encode_unit: IR capture and Ra/Rb/Rc register-select decode
//   clk, clr        : clock, asynchronous active-low reset
//   IRin, bus_in    : load IR from the bus
//   Gra/Grb/Grc     : field select, priority Ra > Rb > Rc
//   Rin/Rout/BAout  : write (edge-qualified), drive, base-address drive
//   enableReg       : registered one-hot write pulse
//   R_out, r0_zero  : registered one-hot drive request, r0 forced-zero gate
//   C_sign_ext      : sign-extended C field of IR
//   opcode          : IR opcode field
//   sel_err         : sticky multiple-select flag, cleared by IRin
module select_encode_unit
    import select_encode_unit_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic              clk,
    input  logic              clr,
    input  logic              IRin,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Grc,
    input  logic              Rin,
    input  logic              Rout,
    input  logic              BAout,
    output logic [NREG-1:0]   enableReg,
    output logic [NREG-1:0]   R_out,
    output logic              r0_zero,
    output logic [DATA_W-1:0] C_sign_ext,
    output logic [OPC_W-1:0]  opcode,
    output logic              sel_err
);
    logic [DATA_W-1:0] ir_q;
    logic              rin_q, sel_err_q, r0_zero_q;
    logic [NREG-1:0]   en_q, rout_q;
    logic [FLD_W-1:0]  sel;
    logic              wr_edge, drive, conflict, sel_err_d;
    logic [NREG-1:0]   en_d, rout_d;

    assign sel = Gra ? field(ir_q, RA_MSB) :
                 Grb ? field(ir_q, RB_MSB) :
                 Grc ? field(ir_q, RC_MSB) : '0;

    assign wr_edge  = Rin & ~rin_q;
    assign drive    = Rout | BAout;
    assign conflict = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
    // a conflict seen while IR reloads still flags, since it was decoded against the old IR
    assign sel_err_d = conflict | (sel_err_q & ~IRin);

    decoder_4to16 u_wr_dec (.en_i(wr_edge), .sel_i(sel), .y_o(en_d));
    decoder_4to16 u_rd_dec (.en_i(drive),   .sel_i(sel), .y_o(rout_d));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ir_q      <= '0;
            rin_q     <= 1'b0;
            sel_err_q <= 1'b0;
            en_q      <= '0;
            rout_q    <= '0;
            r0_zero_q <= 1'b0;
        end else begin
            ir_q      <= IRin ? bus_in : ir_q;
            rin_q     <= Rin;
            sel_err_q <= sel_err_d;
            en_q      <= en_d;
            rout_q    <= rout_d;
            r0_zero_q <= BAout & (sel == '0);
        end
    end

    assign enableReg  = en_q;
    assign R_out      = rout_q;
    assign r0_zero    = r0_zero_q;
    assign sel_err    = sel_err_q;
    assign opcode     = ir_q[OPC_MSB -: OPC_W];
    assign C_sign_ext = {{(DATA_W-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};
endmodule
